vecvec_mac: RTL
===============

Name: vecvec_mac

Overview:
- Parametrised, multi-cycle signed fixed-point dot-product engine. Next generation of the fixed-size vecvecN blocks.
- Vector length, lane count (MACs per cycle) and overflow mode are all parameters.
- Operands are latched on a start handshake, so callers no longer hold `rst` to restart.
- Sits between the vector register file and the navigation math pipeline. Reports overflow explicitly.

Parameters:
- DATA_WIDTH, 16, element and result width; signed two's complement fixed point.
- BIN_POS, 8, fractional bits (binary point position); 0 <= BIN_POS < DATA_WIDTH.
- VECTOR_SIZE, 4, element count N; >= 1.
- LANES, 2, elements multiplied and accumulated per cycle; 1 <= LANES <= VECTOR_SIZE.
- SATURATE, 1, 1 = clamp result on overflow; 0 = wrap (keep low DATA_WIDTH bits).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only while ready=1.
- ready  out  1  engine can accept start.
- complete  out  1  dot/overflow valid.
- vec_a  in  VECTOR_SIZE*DATA_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH].
- vec_b  in  VECTOR_SIZE*DATA_WIDTH  same packing as vec_a.
- dot  out  DATA_WIDTH  result.
- overflow  out  1  result exceeded the DATA_WIDTH range.

Behaviour:
- Reset: one clock, synchronous, active-high (`clk`, `rst`). Takes priority over everything, including mid-RUN; aborts the operation with no partial result.
  - state=IDLE, ready=1, complete=0, dot=0, overflow=0, acc=0, idx=0.
- K = ceil(VECTOR_SIZE/LANES) = number of RUN cycles.
- Accumulator: ACC_W = 2*DATA_WIDTH + clog2(VECTOR_SIZE)+1 bits, signed. Never overflows internally.
- IDLE: ready=1, complete=0.
  - start=1 at an edge: latch vec_a/vec_b into internal regs, acc<=0, idx<=0, go to RUN.
- RUN: ready=0.
  - Each edge adds LANES full-precision signed products a[idx+j]*b[idx+j] (2*DATA_WIDTH bits each) to acc, then idx<=idx+LANES.
  - Lanes with idx+j >= VECTOR_SIZE contribute 0.
  - Input ports are ignored during RUN; changes to vec_a/vec_b have no effect. start is ignored.
  - On the K-th RUN edge, compute final = acc + lane sum, then:
    - r = final >>> BIN_POS (arithmetic shift; truncation toward -inf).
    - If r is outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]: overflow<=1; dot<=saturated bound if SATURATE=1, else r[DATA_WIDTH-1:0].
    - Otherwise overflow<=0, dot<=r.
    - Go to DONE.
- Latency: start sampled at edge E0 -> complete=1 after edge E_K.
- DONE: complete=1, ready=1; dot/overflow held stable.
  - start=1: latch new operands (same as IDLE) and go to RUN; complete drops after that edge. Back-to-back operations have no idle bubble.
  - start=0: stay in DONE indefinitely.
- dot and overflow change only on DONE entry or reset.
- No combinational path from any input to ready or complete.

Test Plan:
- Basic, DATA_WIDTH=16, BIN_POS=8, N=4, LANES=2, SATURATE=1: vec_a={0x0400,0x0300,0x0200,0x0100} (elements 3..0), vec_b all 0x0100, start pulsed at E0 -> ready=0 after E0; complete=1 exactly after E2; dot=0x0A00; overflow=0; ready=1.
- Sign and truncation: a0=0xFE80 (-1.5), b0=0x0200, others 0 -> dot=0xFD00. Separately a0=0xFFFF, b0=0x0080, others 0 -> dot=0xFFFF (floor of -1/512).
- Overflow: all a and b = 0x7F00.
  - SATURATE=1 -> dot=0x7FFF, overflow=1.
  - SATURATE=0 -> dot=0x0400, overflow=1.
  - Next operation with a0=b0=0x0100, others 0 -> overflow=0, dot=0x0100.
- Ragged lanes, N=5, LANES=2: all elements 0x0100 -> complete after E3 (K=3); dot=0x0500. Repeat with LANES=1 (complete after E5) and LANES=5 (complete after E1); same dot.
- Operand latching and back-to-back:
  - Change vec_a every cycle during RUN -> result reflects the values present at E0.
  - Assert start in the first DONE cycle with new operands -> complete drops for exactly K cycles, then the new dot appears.
  - start during RUN -> ignored.
- Reset mid-operation: assert rst one cycle at E1 of a K=2 run -> after that edge: ready=1, complete=0, dot=0, overflow=0. A new start yields a correct result with no stale accumulation.

Source files
------------

// File: rtl/vecvec_mac.sv
`default_nettype none
// ============================================================================
// Module      : vecvec_mac
// Description : Multi-cycle signed fixed-point dot-product engine.
//               Operands are latched on a start handshake, then LANES
//               element products are accumulated per clock at full precision.
//               The final sum is rescaled by BIN_POS and either saturated or
//               wrapped to DATA_WIDTH. Overflow is reported explicitly.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous reset, active-high
//               start    - request, sampled only while ready=1
//               ready    - engine can accept start
//               complete - dot/overflow valid
//               vec_a    - element i at [i*DATA_WIDTH +: DATA_WIDTH]
//               vec_b    - same packing as vec_a
//               dot      - scaled result
//               overflow - result exceeded the DATA_WIDTH range
// Revision    : 1.0 - initial release
// ============================================================================
module vecvec_mac #(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int VECTOR_SIZE = 4,
    parameter int LANES       = 2,
    parameter int SATURATE    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              ready,
    output logic                              complete,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_a,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_b,
    output logic [DATA_WIDTH-1:0]             dot,
    output logic                              overflow
);

    localparam int C_ACC_W  = 2*DATA_WIDTH + $clog2(VECTOR_SIZE) + 1;
    localparam int C_PRD_W  = 2*DATA_WIDTH;
    localparam int C_VEC_W  = VECTOR_SIZE*DATA_WIDTH;
    localparam int C_LANE_W = LANES*DATA_WIDTH;
    // idx must be able to hold the first value past the end of the vector
    localparam int C_IDX_W  = $clog2(VECTOR_SIZE + LANES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [C_VEC_W-1:0]          r_a;
    logic [C_VEC_W-1:0]          r_b;
    logic [C_VEC_W-1:0]          w_a_nxt;
    logic [C_VEC_W-1:0]          w_b_nxt;
    logic signed [C_ACC_W-1:0]   r_acc;
    logic signed [C_ACC_W-1:0]   w_lane_sum;
    logic signed [C_ACC_W-1:0]   w_final;
    logic signed [C_ACC_W-1:0]   w_shift;
    logic signed [C_PRD_W-1:0]   w_prod [LANES];
    logic [C_IDX_W-1:0]          r_idx;
    logic                        w_last;
    logic                        w_ovf;
    logic [DATA_WIDTH-1:0]       w_dot_nxt;

    // The latched operands are consumed from the bottom: after every RUN
    // cycle they shift down by one lane group, so lane j always reads slot j.
    // Zero fill from the top makes lanes past the vector end contribute 0.
    if (LANES < VECTOR_SIZE) begin : g_shift
        assign w_a_nxt = {{C_LANE_W{1'b0}}, r_a[C_VEC_W-1:C_LANE_W]};
        assign w_b_nxt = {{C_LANE_W{1'b0}}, r_b[C_VEC_W-1:C_LANE_W]};
    end else begin : g_no_shift
        assign w_a_nxt = '0;
        assign w_b_nxt = '0;
    end

    // Operands are sign-extended to the product width first so the multiply
    // yields the exact full-precision signed product.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic signed [C_PRD_W-1:0] w_ext_a;
        logic signed [C_PRD_W-1:0] w_ext_b;
        assign w_ext_a = {{DATA_WIDTH{r_a[j*DATA_WIDTH+DATA_WIDTH-1]}},
                          r_a[j*DATA_WIDTH +: DATA_WIDTH]};
        assign w_ext_b = {{DATA_WIDTH{r_b[j*DATA_WIDTH+DATA_WIDTH-1]}},
                          r_b[j*DATA_WIDTH +: DATA_WIDTH]};
        assign w_prod[j] = w_ext_a * w_ext_b;
    end

    always_comb begin
        w_lane_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            w_lane_sum = w_lane_sum +
                {{(C_ACC_W-C_PRD_W){w_prod[j][C_PRD_W-1]}}, w_prod[j]};
        end
    end

    assign w_final = r_acc + w_lane_sum;
    assign w_shift = w_final >>> BIN_POS;
    assign w_last  = (r_idx + C_IDX_W'(LANES)) >= C_IDX_W'(VECTOR_SIZE);

    // In range only when every bit from the result sign bit upward agrees.
    assign w_ovf = !((&w_shift[C_ACC_W-1:DATA_WIDTH-1]) ||
                     !(|w_shift[C_ACC_W-1:DATA_WIDTH-1]));

    always_comb begin
        w_dot_nxt = w_shift[DATA_WIDTH-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            w_dot_nxt = w_shift[C_ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs come straight from the state register.
    assign ready    = (r_state != ST_RUN);
    assign complete = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            dot      <= '0;
            overflow <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_acc <= w_final;
            r_idx <= r_idx + C_IDX_W'(LANES);
            if (w_last) begin
                dot      <= w_dot_nxt;
                overflow <= w_ovf;
            end
        end else if (start) begin
            r_a   <= vec_a;
            r_b   <= vec_b;
            r_acc <= '0;
            r_idx <= '0;
        end
    end

endmodule
`default_nettype wire
